sensor_serial_uc: RTL

- Control unit that sequences one ultrasonic measurement and its serial report.
- Sits beside the HC-SR04 interface and the 7O1 serial transmitter. Pulses the interface's measure request and waits for its done strobe with a timeout.
- Latches the 12-bit BCD distance. Sends it as four ASCII characters (hundreds, tens, units, separator) through the transmitter, one character per start/done handshake.
- Moore outputs only; `db_estado` feeds a 7-segment display.

---
 rtl/sensor_serial_uc.sv | 109 ++++++++++
 1 files changed

// File: rtl/sensor_serial_uc.sv
// sensor_serial_uc: sequences one ultrasonic measurement and its 4-character serial report
// Ports: clock/reset (async active-low); medir starts a cycle.
// Sensor handshake: medir_sensor request, then sensor_pronto/sensor_medida (12-bit BCD).
// Transmitter handshake: tx_partida/tx_dados out, tx_pronto back.
// Status: pronto ends a cycle, timeout flags an aborted measurement, db_estado shows the state code.
// SENSOR_UC_PERIODIC_EN: also starts a cycle after PERIOD_CYCLES idle cycles in INICIAL.
module sensor_serial_uc #(
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter logic [6:0] SEPARATOR = 7'h23,
  parameter int PERIOD_CYCLES = 25000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        sensor_pronto,
  input  logic [11:0] sensor_medida,
  input  logic        tx_pronto,
  output logic        medir_sensor,
  output logic        tx_partida,
  output logic [6:0]  tx_dados,
  output logic        pronto,
  output logic        timeout,
  output logic [3:0]  db_estado
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [3:0] {
    INICIAL = 4'd0, MEDE = 4'd1, AGUARDA_MEDIDA = 4'd2, ARMAZENA = 4'd3,
    TX_CHAR = 4'd4, AGUARDA_TX = 4'd5, PROXIMO = 4'd6, FINAL = 4'd7, ERRO = 4'hE
  } state_t;
  state_t state;
  logic [TW-1:0] cnt;
  logic [11:0] dig;
  logic [1:0] idx, ni;
  logic [3:0] nd;
  logic [6:0] nxt_char;
  logic start;
  assign db_estado = state;
`ifdef SENSOR_UC_PERIODIC_EN
  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  logic [PW-1:0] pcnt;
  assign start = medir | (pcnt == PW'(PERIOD_CYCLES - 1));
  always_ff @(posedge clock or negedge reset)
    if (!reset) pcnt <= '0;
    else pcnt <= (state != INICIAL || start) ? '0 : pcnt + 1'b1;
`else
  logic unused_period;
  assign unused_period = ^PERIOD_CYCLES;
  assign start = medir;
`endif
  // Character for the index about to be loaded on entry to TX_CHAR
  always_comb begin
    ni = (state == PROXIMO) ? idx + 2'd1 : 2'd0;
    nd = (ni == 2'd0) ? dig[11:8] : (ni == 2'd1) ? dig[7:4] : dig[3:0];
    nxt_char = (ni == 2'd3) ? SEPARATOR : (nd > 4'd9) ? 7'h3F : 7'h30 + {3'b0, nd};
  end
  // Outputs are set on the transition into the state that owns them
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= INICIAL;
      medir_sensor <= 1'b0;
      tx_partida <= 1'b0;
      tx_dados <= '0;
      pronto <= 1'b0;
      timeout <= 1'b0;
      dig <= '0;
      idx <= '0;
      cnt <= '0;
    end else begin
      medir_sensor <= 1'b0;
      tx_partida <= 1'b0;
      pronto <= 1'b0;
      case (state)
        INICIAL: if (start) begin
          state <= MEDE;
          medir_sensor <= 1'b1;
          timeout <= 1'b0;
        end
        MEDE: begin
          state <= AGUARDA_MEDIDA;
          cnt <= '0;
        end
        AGUARDA_MEDIDA: begin
          cnt <= cnt + 1'b1;
          if (sensor_pronto) begin
            state <= ARMAZENA;
            dig <= sensor_medida;
          end else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state <= FINAL;
            timeout <= 1'b1;
            pronto <= 1'b1;
          end
        end
        ARMAZENA, PROXIMO: if (state == PROXIMO && idx == 2'd3) begin
          state <= FINAL;
          pronto <= 1'b1;
        end else begin
          state <= TX_CHAR;
          idx <= ni;
          tx_partida <= 1'b1;
          tx_dados <= nxt_char;
        end
        TX_CHAR: state <= AGUARDA_TX;
        AGUARDA_TX: if (tx_pronto) state <= PROXIMO;
        FINAL: state <= INICIAL;
        ERRO: state <= INICIAL;
        default: state <= INICIAL;
      endcase
    end
endmodule
